// File: rtl/in_cond_sync_debounce.sv
// in_cond_sync_debounce: four-channel pad conditioner ahead of the AND detector.
// Each raw input is double-flop synchronised and debounced. The block also
// produces a registered all-high level and a one-cycle rise pulse.
// Optional build macro IN_COND_EVENT_CNT_EN adds a 2-bit rise-event counter
// with a synchronised clear. Without it, io_out[7:6] reads 2'b00.

// One debounce channel: a two-flop synchroniser followed by a stability counter.
module in_cond_deb_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  // Synchronise, then let deb follow s2 only after CNT_LAST+1 straight disagreements.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= 4'd0;
      deb <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= 4'd0;                 // any agreeing sample restarts the count
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module in_cond_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam int NUM_LANES = 4;

  logic                 clk;
  logic                 reset;
  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] deb;
  logic                 all_hi;
  logic                 all_rise;
  logic [1:0]           evt_cnt;
  logic                 rise_cond;

  assign clk   = io_in[0];
  assign reset = io_in[1];
  assign raw   = io_in[5:2];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    in_cond_deb_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[k]),
      .deb  (deb[k])
    );
  end

  // All channels high now but not last cycle: the start of an all-high period.
  assign rise_cond = (&deb) & ~all_hi;

  // Registered all-high level and its single-cycle rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      all_hi   <= 1'b0;
      all_rise <= 1'b0;
    end else begin
      all_hi   <= &deb;
      all_rise <= rise_cond;
    end
  end

`ifdef IN_COND_EVENT_CNT_EN
  logic clr_s1;
  logic clr_s2;
  logic unused_in;

  assign unused_in = io_in[7];

  // Count rise events modulo 4; a synchronised clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
      evt_cnt <= 2'b00;
    end else begin
      clr_s1 <= io_in[6];
      clr_s2 <= clr_s1;
      if (clr_s2)         evt_cnt <= 2'b00;
      else if (rise_cond) evt_cnt <= evt_cnt + 2'd1;
    end
  end
`else
  logic unused_in;

  assign unused_in = ^io_in[7:6];
  assign evt_cnt   = 2'b00;
`endif

  assign io_out = {evt_cnt, all_rise, all_hi, deb};
endmodule

// File: tb/tb_in_cond_sync_debounce.sv
// Directed bench for in_cond_sync_debounce. A window-based reference model is
// checked against io_out after every clock edge. Literal checks at key
// points pin the model to hand-derived values.
module tb_in_cond_sync_debounce;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, clr, junk;
  logic [3:0] raw;
  logic [7:0] io_in, io_out;
  int         total = 0;
  int         bad = 0;

  assign io_in = {junk, clr, raw, reset, clk};

  in_cond_sync_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ev(input int n);
`ifdef IN_COND_EVENT_CNT_EN
    return 2'(n);
`else
    return 2'b00;
`endif
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model. deb[k] flips once the last D synchronised samples all
  // disagree with it. The synchronisers are modelled as two-deep delay lines.
  logic [3:0]  m_s1 = 0, m_s2 = 0, m_deb = 0;
  logic [14:0] win [4];
  logic        m_hi = 0, m_rise = 0, m_c1 = 0, m_c2 = 0, started = 0;
  int          m_evt = 0;

  always @(posedge clk) begin
    logic       r_s, c_s, n_hi, n_rise;
    logic [3:0] raw_s;
    logic [14:0] mask, w;
    logic [1:0] exp_evt;
    r_s = reset; c_s = clr; raw_s = raw;
    #1;
    if (r_s) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_hi = 0; m_rise = 0;
      m_c1 = 0; m_c2 = 0; m_evt = 0; started = 1;
      for (int k = 0; k < 4; k++) win[k] = '0;
    end else begin
      n_hi   = &m_deb;
      n_rise = n_hi & ~m_hi;
      if (m_c2) m_evt = 0;
      else if (n_rise) m_evt = (m_evt + 1) % 4;
      mask = 15'((1 << D) - 1);
      for (int k = 0; k < 4; k++) begin
        win[k] = {win[k][13:0], m_s2[k]};
        w = win[k] & mask;
        if ((m_deb[k] == 1'b0 && w == mask) || (m_deb[k] == 1'b1 && w == 15'd0))
          m_deb[k] = ~m_deb[k];
      end
      m_hi = n_hi; m_rise = n_rise;
      m_s2 = m_s1; m_s1 = raw_s;
      m_c2 = m_c1; m_c1 = c_s;
    end
    if (started) begin
      exp_evt = ev(m_evt);
      chk("model", io_out, {exp_evt, m_rise, m_hi, m_deb});
    end
  end

  initial begin
    reset = 1'b1; raw = 4'hF; clr = 1'b0; junk = 1'b0;
    // Reset held three cycles with inputs high: everything reads zero.
    edges(1); chk("rst_c0", io_out, 8'h00);
    edges(1); chk("rst_c1", io_out, 8'h00);
    junk = 1'b1;
    edges(1); chk("rst_c2", io_out, 8'h00);
    reset = 1'b0;
    edges(1); chk("rel_e1", io_out, 8'h00);
    edges(4); chk("rel_e5", io_out, 8'h00);
    edges(1); chk("rel_e6", io_out, 8'h0F);
    edges(1); chk("rel_e7", io_out, {ev(1), 2'b11, 4'hF});
    edges(1); chk("rel_e8", io_out, {ev(1), 2'b01, 4'hF});

    // Glitch rejection on channel 1.
    raw = 4'h0; junk = 1'b0;
    edges(8); chk("low_all", io_out[5:0], 6'h00);
    raw = 4'h2; edges(3); raw = 4'h0;
    edges(8); chk("glitch3", io_out[3:0], 4'h0);
    raw = 4'h2;
    edges(5); chk("ch1_e5", io_out[3:0], 4'h0);
    edges(1); chk("ch1_e6", io_out[3:0], 4'h2);

    // 7 -> F produces one all_rise pulse.
    raw = 4'h7;
    edges(8); chk("deb7", io_out[5:0], 6'h07);
    raw = 4'hF;
    edges(6); chk("hi_e6", io_out[5:0], 6'h0F);
    edges(1); chk("hi_e7", io_out, {ev(2), 2'b11, 4'hF});
    edges(1); chk("hi_e8", io_out, {ev(2), 2'b01, 4'hF});

    // Three more rise events: five in total, counter wraps to 1.
    repeat (3) begin
      raw = 4'hE; edges(8);
      raw = 4'hF; edges(8);
    end
    chk("wrap", {6'd0, io_out[7:6]}, {6'd0, ev(1)});

    // Clear lands on the same edge as a rise event; the clear wins.
    raw = 4'hE; edges(8);
    raw = 4'hF; edges(4);
    clr = 1'b1; edges(1);
    clr = 1'b0; edges(1);
    chk("clr_e6", io_out, {ev(1), 2'b00, 4'hF});
    edges(1); chk("clr_e7", io_out, {2'b00, 2'b11, 4'hF});
    edges(1); chk("clr_e8", io_out, {2'b00, 2'b01, 4'hF});

    // Reset mid-debounce discards the partial count on channel 0.
    raw = 4'h0; edges(8);
    chk("pre_mid", io_out[3:0], 4'h0);
    raw = 4'h1; edges(4);
    reset = 1'b1; edges(1);
    reset = 1'b0;
    edges(5); chk("mid_e5", io_out, 8'h00);
    edges(1); chk("mid_e6", io_out, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
